// File: rtl/logic_vector_checker_if.sv
// rtl/logic_vector_checker_if.sv - stimulus/response and result bundle of the vector checker
interface logic_vector_checker_if;
   logic       start;
   logic       y_in;
   logic       a;
   logic       b;
   logic       c;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_count;
   logic [7:0] fail_mask;

   modport master (
      input  start, y_in,
      output a, b, c, busy, done, pass, err_count, fail_mask
   );

   modport slave (
      output start, y_in,
      input  a, b, c, busy, done, pass, err_count, fail_mask
   );
endinterface

// File: rtl/logic_vector_checker.sv
// rtl/logic_vector_checker.sv - exhaustive 3-input sweep of a (a&b)|c gate with mismatch tracking
module logic_vector_checker #(
   parameter int SETTLE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   logic_vector_checker_if.master bus
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

   state_t     state_q;
   logic [2:0] idx_q;
   logic [3:0] cnt_q;
   logic [2:0] abc_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [3:0] err_q;
   logic [7:0] mask_q;

   logic       exp_y;
   logic       mismatch;
   logic [3:0] err_d;
   logic [7:0] mask_d;

   // Reference is taken from the vector actually on the pins, not from idx_q.
   always_comb begin
      exp_y    = (abc_q[2] & abc_q[1]) | abc_q[0];
      mismatch = (state_q == SAMPLE) && (bus.y_in != exp_y);
      err_d    = err_q;
      mask_d   = mask_q;
      if (mismatch) begin
         mask_d = mask_q | (8'b1 << idx_q);
         if (err_q != 4'd8) begin
            err_d = err_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         cnt_q   <= 4'd0;
         abc_q   <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 4'd0;
         mask_q  <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q <= DRIVE;
                  idx_q   <= 3'd0;
                  cnt_q   <= 4'd0;
                  abc_q   <= 3'd0;
                  err_q   <= 4'd0;
                  mask_q  <= 8'd0;
                  busy_q  <= 1'b1;
               end
            end
            DRIVE: begin
               if (cnt_q == SETTLE_M1) begin
                  state_q <= SAMPLE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            SAMPLE: begin
               err_q  <= err_d;
               mask_q <= mask_d;
               if (idx_q == 3'd7) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == 4'd0);
               end else begin
                  state_q <= DRIVE;
                  idx_q   <= idx_q + 3'd1;
                  abc_q   <= idx_q + 3'd1;
                  cnt_q   <= 4'd0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               pass_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.a         = abc_q[2];
   assign bus.b         = abc_q[1];
   assign bus.c         = abc_q[0];
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.fail_mask = mask_q;

endmodule

// File: tb/tb_logic_vector_checker.sv
// tb/tb_logic_vector_checker.sv - directed sweeps with a result scoreboard on SETTLE=1 and SETTLE=3 instances
module tb_logic_vector_checker;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic_vector_checker_if if1 ();
   logic_vector_checker_if if3 ();

   logic_vector_checker #(.SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
   logic_vector_checker #(.SETTLE(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.master));

   int mode1 = 0;
   int mode3 = 0;
   int total = 0;
   int passed = 0;

   typedef struct {
      logic [3:0] err;
      logic [7:0] mask;
      logic       pass;
      int         lat;
   } exp_t;
   exp_t sb[$];

   // 0: correct gate, 1: stuck at 0, 2: or-gate, 3: stuck at 1
   function automatic logic gate(input int mode, input logic [2:0] v);
      case (mode)
         0:       return (v[2] & v[1]) | v[0];
         1:       return 1'b0;
         2:       return |v;
         default: return 1'b1;
      endcase
   endfunction

   assign if1.y_in = gate(mode1, {if1.a, if1.b, if1.c});
   assign if3.y_in = gate(mode3, {if3.a, if3.b, if3.c});

   function automatic int vec_of(input int sel);
      return (sel == 3) ? int'({if3.a, if3.b, if3.c}) : int'({if1.a, if1.b, if1.c});
   endfunction
   function automatic logic busy_of(input int sel);
      return (sel == 3) ? if3.busy : if1.busy;
   endfunction
   function automatic logic done_of(input int sel);
      return (sel == 3) ? if3.done : if1.done;
   endfunction
   function automatic logic pass_of(input int sel);
      return (sel == 3) ? if3.pass : if1.pass;
   endfunction
   function automatic logic [3:0] err_of(input int sel);
      return (sel == 3) ? if3.err_count : if1.err_count;
   endfunction
   function automatic logic [7:0] mask_of(input int sel);
      return (sel == 3) ? if3.fail_mask : if1.fail_mask;
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel == 3) if3.start = v;
      else          if1.start = v;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Caller is at #1 after a rising edge; the next edge accepts start.
   task automatic sweep(input int sel, input int mode, input bit repulse);
      int         s;
      exp_t       e;
      exp_t       got;
      logic [7:0] m;
      int         v;
      int         prev;
      int         hold;
      bit         order_ok;
      bit         hold_ok;
      bit         pass_ok;
      bit         seen;
      s = (sel == 3) ? 3 : 1;
      if (sel == 3) mode3 = mode;
      else          mode1 = mode;
      m = 8'd0;
      for (int i = 0; i < 8; i++) begin
         if (gate(mode, 3'(i)) !== gate(0, 3'(i))) m[i] = 1'b1;
      end
      e.err  = 4'($countones(m));
      e.mask = m;
      e.pass = (m == 8'd0);
      e.lat  = 8 * (s + 1) + 1;
      sb.push_back(e);

      set_start(sel, 1'b1);
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      chk("busy_after_start", 32'(busy_of(sel)), 32'd1);

      prev = -1; hold = 0; order_ok = 1; hold_ok = 1; pass_ok = 1; seen = 0;
      got.lat = -1;
      for (int n = 0; n < 8 * (s + 1) + 4 && !seen; n++) begin
         if (n > 0) begin
            @(posedge clk); #1;
         end
         if (repulse && n == 5) set_start(sel, 1'b0);
         v = vec_of(sel);
         if (v == prev) begin
            hold++;
         end else begin
            if (prev >= 0 && hold != s + 1) hold_ok = 0;
            if (v != prev + 1) order_ok = 0;
            prev = v;
            hold = 1;
         end
         if (done_of(sel)) begin
            seen     = 1;
            got.lat  = n + 1;
            got.err  = err_of(sel);
            got.mask = mask_of(sel);
            got.pass = pass_of(sel);
         end else if (pass_of(sel)) begin
            pass_ok = 0;
         end
         if (repulse && n == 4) set_start(sel, 1'b1);
      end
      if (repulse) set_start(sel, 1'b1);

      e = sb.pop_front();
      chk("done_latency", 32'(got.lat), 32'(e.lat));
      chk("err_count", 32'(got.err), 32'(e.err));
      chk("fail_mask", 32'(got.mask), 32'(e.mask));
      chk("pass", 32'(got.pass), 32'(e.pass));
      chk("vector_order", 32'(order_ok), 32'd1);
      chk("vector_hold", 32'(hold_ok), 32'd1);
      chk("last_vector", 32'(prev), 32'd7);
      chk("pass_outside_done", 32'(pass_ok), 32'd1);

      @(posedge clk); #1;
      set_start(sel, 1'b0);
      chk("done_one_cycle", 32'(done_of(sel)), 32'd0);
      chk("pass_cleared", 32'(pass_of(sel)), 32'd0);
      chk("idle_after_done", 32'(busy_of(sel)), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("no_relaunch", 32'(busy_of(sel)), 32'd0);
      chk("err_hold", 32'(err_of(sel)), 32'(e.err));
      chk("mask_hold", 32'(mask_of(sel)), 32'(e.mask));
      chk("abc_hold", 32'(vec_of(sel)), 32'd7);
   endtask

   task automatic chk_zero(input string tag, input int sel);
      chk({tag, "_abc"}, 32'(vec_of(sel)), 32'd0);
      chk({tag, "_busy"}, 32'(busy_of(sel)), 32'd0);
      chk({tag, "_done"}, 32'(done_of(sel)), 32'd0);
      chk({tag, "_pass"}, 32'(pass_of(sel)), 32'd0);
      chk({tag, "_err"}, 32'(err_of(sel)), 32'd0);
      chk({tag, "_mask"}, 32'(mask_of(sel)), 32'd0);
   endtask

   initial begin
      bit done_seen;
      rst_n     = 1'b0;
      if1.start = 1'b1;
      if3.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset", 1);
      chk_zero("reset3", 3);
      if1.start = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk); #1;
      chk("start_in_reset_ignored", 32'(if1.busy), 32'd0);

      sweep(1, 0, 0);
      sweep(1, 1, 0);
      sweep(1, 2, 0);
      sweep(1, 3, 0);
      sweep(1, 0, 0);
      sweep(3, 0, 1);

      mode1 = 1;
      if1.start = 1'b1;
      @(posedge clk); #1;
      if1.start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("pre_reset_err", 32'(if1.err_count), 32'd2);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_zero("midsweep_reset", 1);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (if1.done || if1.busy) done_seen = 1;
      end
      chk("idle_after_reset", 32'(done_seen), 32'd0);
      sweep(1, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
